// File: rtl/bus_err_pkg.sv
// Shared width helpers and error-record layout for the ID-tracked bus error unit.
package bus_err_pkg;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned rec_width(input int unsigned err_bits, input int unsigned id_w,
                                              input int unsigned addr_w, input int unsigned meta_w);
        return err_bits + id_w + addr_w + meta_w + 1;
    endfunction

    // Error records are packed MSB first in this order.
    localparam string ERR_REC_FIELDS = "{err, id, addr, meta, addr_valid}";

endpackage

// File: rtl/bus_err_id_tracker.sv
// Per-ID request tracker: address FIFO plus untracked-request counter for lossless resync.
module bus_err_id_tracker
    import bus_err_pkg::*;
#(
    parameter int unsigned AddrWidth         = 48,
    parameter int unsigned MetaDataWidth     = 1,
    parameter int unsigned NumOutstanding    = 4,
    parameter int unsigned UntrackedCntWidth = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     testmode_i,
    input  logic                     req_i,
    input  logic [AddrWidth-1:0]     addr_i,
    input  logic [MetaDataWidth-1:0] meta_i,
    input  logic                     rsp_last_i,
    input  logic                     desync_clr_i,
    output logic                     head_valid_o,
    output logic [AddrWidth-1:0]     head_addr_o,
    output logic [MetaDataWidth-1:0] head_meta_o,
    output logic                     desync_o
);
    localparam int unsigned CW = cnt_width(NumOutstanding);

    logic                               empty, full, pop, push, dec, inc, spurious, u_sat;
    logic [CW-1:0]                      usage;
    logic [UntrackedCntWidth-1:0]       u_cnt;
    logic [AddrWidth+MetaDataWidth-1:0] head;

    // All decisions use pre-cycle state; requests bypass the FIFO while any are untracked.
    assign full     = (usage == CW'(NumOutstanding));
    assign pop      = rsp_last_i & ~empty;
    assign dec      = rsp_last_i & empty & (u_cnt != '0);
    assign spurious = rsp_last_i & empty & (u_cnt == '0);
    assign push     = req_i & (u_cnt == '0) & (~full | pop);
    assign inc      = req_i & ~push;
    assign u_sat    = &u_cnt;

    fifo_v3 #(
        .DEPTH      (NumOutstanding),
        .DATA_WIDTH (AddrWidth + MetaDataWidth)
    ) u_addr_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (testmode_i),
        .push_i     (push),
        .data_i     ({addr_i, meta_i}),
        .pop_i      (pop),
        .data_o     (head),
        .empty_o    (empty),
        .usage_o    (usage)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            u_cnt    <= '0;
            desync_o <= 1'b0;
        end else begin
            if (inc && !dec && !u_sat) u_cnt <= u_cnt + UntrackedCntWidth'(1);
            else if (dec && !inc)      u_cnt <= u_cnt - UntrackedCntWidth'(1);
            if (spurious || (inc && !dec && u_sat)) desync_o <= 1'b1;
            else if (desync_clr_i)                  desync_o <= 1'b0;
        end
    end

    assign head_valid_o              = ~empty;
    assign {head_addr_o, head_meta_o} = head;

endmodule

// File: rtl/fifo_v3.sv
// Simple synchronous FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module fifo_v3
    import bus_err_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic                        testmode_i,
    input  logic                        push_i,
    input  logic [DATA_WIDTH-1:0]       data_i,
    input  logic                        pop_i,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic                        empty_o,
    output logic [cnt_width(DEPTH)-1:0] usage_o
);
    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         cnt;
    logic                  do_pop, do_push, do_flush;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Flush is suppressed in test mode so scan shifting cannot clear contents.
    assign do_flush = flush_i & ~testmode_i;
    assign do_pop   = pop_i & (cnt != '0);
    assign do_push  = push_i & ((cnt != CW'(DEPTH)) | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (do_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

    assign data_o  = mem[rd_ptr];
    assign empty_o = (cnt == '0);
    assign usage_o = cnt;

endmodule

// File: rtl/bus_err_unit_id_tracked.sv
// Bus error unit for ID-tagged buses: pairs erroring responses with per-ID requests and queues records.
module bus_err_unit_id_tracked
    import bus_err_pkg::*;
#(
    parameter int unsigned AddrWidth         = 48,
    parameter int unsigned MetaDataWidth     = 1,
    parameter int unsigned ErrBits           = 3,
    parameter int unsigned IdWidth           = 2,
    parameter int unsigned NumOutstanding    = 4,
    parameter int unsigned UntrackedCntWidth = 6,
    parameter int unsigned NumStoredErrors   = 4,
    parameter int unsigned DropCntWidth      = 16,
    parameter logic        DropOldest        = 1'b0
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  testmode_i,
    input  logic                                  req_valid_i,
    input  logic [IdWidth-1:0]                    req_id_i,
    input  logic [AddrWidth-1:0]                  req_addr_i,
    input  logic [MetaDataWidth-1:0]              req_meta_i,
    input  logic                                  rsp_valid_i,
    input  logic                                  rsp_last_i,
    input  logic [IdWidth-1:0]                    rsp_id_i,
    input  logic [ErrBits-1:0]                    rsp_err_i,
    input  logic [ErrBits-1:0]                    err_mask_i,
    input  logic [cnt_width(NumStoredErrors)-1:0] irq_threshold_i,
    output logic                                  err_irq_o,
    output logic                                  err_valid_o,
    input  logic                                  err_pop_i,
    output logic [ErrBits-1:0]                    err_code_o,
    output logic [IdWidth-1:0]                    err_id_o,
    output logic [AddrWidth-1:0]                  err_addr_o,
    output logic [MetaDataWidth-1:0]              err_meta_o,
    output logic                                  err_addr_valid_o,
    output logic [DropCntWidth-1:0]               err_drop_cnt_o,
    input  logic                                  drop_cnt_clr_i,
    output logic [2**IdWidth-1:0]                 desync_o,
    input  logic [2**IdWidth-1:0]                 desync_clr_i
);
    localparam int unsigned NumIds = 2**IdWidth;
    localparam int unsigned RecW   = rec_width(ErrBits, IdWidth, AddrWidth, MetaDataWidth);
    localparam int unsigned CntW   = cnt_width(NumStoredErrors);

    logic [NumIds-1:0]        head_valid;
    logic [AddrWidth-1:0]     head_addr [NumIds];
    logic [MetaDataWidth-1:0] head_meta [NumIds];

    for (genvar i = 0; i < NumIds; i++) begin : g_tracker
        bus_err_id_tracker #(
            .AddrWidth         (AddrWidth),
            .MetaDataWidth     (MetaDataWidth),
            .NumOutstanding    (NumOutstanding),
            .UntrackedCntWidth (UntrackedCntWidth)
        ) u_tracker (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .testmode_i   (testmode_i),
            .req_i        (req_valid_i & (req_id_i == IdWidth'(i))),
            .addr_i       (req_addr_i),
            .meta_i       (req_meta_i),
            .rsp_last_i   (rsp_valid_i & rsp_last_i & (rsp_id_i == IdWidth'(i))),
            .desync_clr_i (desync_clr_i[i]),
            .head_valid_o (head_valid[i]),
            .head_addr_o  (head_addr[i]),
            .head_meta_o  (head_meta[i]),
            .desync_o     (desync_o[i])
        );
    end

    logic                     rsp_known, err_hit, err_empty, err_full, user_pop, drop;
    logic                     fifo_push, fifo_pop;
    logic [AddrWidth-1:0]     rsp_addr;
    logic [MetaDataWidth-1:0] rsp_meta;
    logic [RecW-1:0]          rec_in, rec_out;
    logic [CntW-1:0]          err_usage, thr_eff;
    logic [ErrBits-1:0]       rec_code;
    logic [IdWidth-1:0]       rec_id;
    logic [AddrWidth-1:0]     rec_addr;
    logic [MetaDataWidth-1:0] rec_meta;
    logic                     rec_av;
    logic [DropCntWidth-1:0]  drop_cnt;
    logic                     irq;

    assign rsp_known = head_valid[rsp_id_i];
    assign rsp_addr  = rsp_known ? head_addr[rsp_id_i] : '0;
    assign rsp_meta  = rsp_known ? head_meta[rsp_id_i] : '0;
    assign err_hit   = rsp_valid_i & (|(rsp_err_i & err_mask_i));
    assign rec_in    = {rsp_err_i, rsp_id_i, rsp_addr, rsp_meta, rsp_known};

    // A user pop frees a slot, so only a full FIFO without a pop loses a record.
    assign err_full  = (err_usage == CntW'(NumStoredErrors));
    assign user_pop  = err_pop_i & ~err_empty;
    assign drop      = err_hit & err_full & ~user_pop;
    assign fifo_push = err_hit & ~(drop & ~DropOldest);
    assign fifo_pop  = user_pop | (drop & DropOldest);

    fifo_v3 #(
        .DEPTH      (NumStoredErrors),
        .DATA_WIDTH (RecW)
    ) u_err_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (testmode_i),
        .push_i     (fifo_push),
        .data_i     (rec_in),
        .pop_i      (fifo_pop),
        .data_o     (rec_out),
        .empty_o    (err_empty),
        .usage_o    (err_usage)
    );

    assign thr_eff = (irq_threshold_i == '0) ? CntW'(1) : irq_threshold_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt <= '0;
            irq      <= 1'b0;
        end else begin
            irq <= (err_usage >= thr_eff);
            if (drop_cnt_clr_i)              drop_cnt <= drop ? DropCntWidth'(1) : '0;
            else if (drop && !(&drop_cnt))   drop_cnt <= drop_cnt + DropCntWidth'(1);
        end
    end

    assign {rec_code, rec_id, rec_addr, rec_meta, rec_av} = rec_out;

    assign err_valid_o      = ~err_empty;
    assign err_code_o       = err_empty ? '0 : rec_code;
    assign err_id_o         = err_empty ? '0 : rec_id;
    assign err_addr_o       = err_empty ? '0 : rec_addr;
    assign err_meta_o       = err_empty ? '0 : rec_meta;
    assign err_addr_valid_o = err_empty ? 1'b0 : rec_av;
    assign err_drop_cnt_o   = drop_cnt;
    assign err_irq_o        = irq;

endmodule

// File: tb/tb_bus_err_unit_id_tracked.sv
// Bench: two DUT copies (discard-new and evict-oldest) against a queue-based reference model.
module tb_bus_err_unit_id_tracked;
    localparam int NO   = 4;
    localparam int NS   = 4;
    localparam int UMAX = 63;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        testmode = 1'b0;
    logic        req_valid, rsp_valid, rsp_last, err_pop, drop_clr;
    logic [1:0]  req_id, rsp_id;
    logic [47:0] req_addr;
    logic [0:0]  req_meta;
    logic [2:0]  rsp_err, err_mask, thr;
    logic [3:0]  desync_clr;

    logic [1:0]  o_irq, o_valid, o_av;
    logic [2:0]  o_code   [2];
    logic [1:0]  o_id     [2];
    logic [47:0] o_addr   [2];
    logic [0:0]  o_meta   [2];
    logic [15:0] o_drop   [2];
    logic [3:0]  o_desync [2];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        bus_err_unit_id_tracked #(.DropOldest(k == 1)) u_dut (
            .clk_i            (clk),
            .rst_ni           (rst_n),
            .testmode_i       (testmode),
            .req_valid_i      (req_valid),
            .req_id_i         (req_id),
            .req_addr_i       (req_addr),
            .req_meta_i       (req_meta),
            .rsp_valid_i      (rsp_valid),
            .rsp_last_i       (rsp_last),
            .rsp_id_i         (rsp_id),
            .rsp_err_i        (rsp_err),
            .err_mask_i       (err_mask),
            .irq_threshold_i  (thr),
            .err_irq_o        (o_irq[k]),
            .err_valid_o      (o_valid[k]),
            .err_pop_i        (err_pop),
            .err_code_o       (o_code[k]),
            .err_id_o         (o_id[k]),
            .err_addr_o       (o_addr[k]),
            .err_meta_o       (o_meta[k]),
            .err_addr_valid_o (o_av[k]),
            .err_drop_cnt_o   (o_drop[k]),
            .drop_cnt_clr_i   (drop_clr),
            .desync_o         (o_desync[k]),
            .desync_clr_i     (desync_clr)
        );
    end

    // Reference model state
    typedef struct packed { logic [47:0] addr; logic meta; } ent_t;
    typedef struct packed { logic [2:0] err; logic [1:0] id; logic [47:0] addr; logic meta; logic av; } rec_t;
    ent_t        trq [4][$];
    int unsigned ucnt [4];
    logic [3:0]  m_desync;
    rec_t        eq [2][$];
    int unsigned m_drop [2];
    logic [1:0]  m_irq;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        req_valid = 0; req_id = 0; req_addr = 0; req_meta = 0;
        rsp_valid = 0; rsp_last = 0; rsp_id = 0; rsp_err = 0;
        err_pop = 0; drop_clr = 0; desync_clr = 0;
    endtask

    task automatic model_step();
        rec_t r;
        ent_t e;
        bit   hit, set, dropped;
        int   t, esz;
        hit    = rsp_valid && ((rsp_err & err_mask) != 0);
        r.err  = rsp_err;
        r.id   = rsp_id;
        r.av   = trq[rsp_id].size() > 0;
        r.addr = r.av ? trq[rsp_id][0].addr : '0;
        r.meta = r.av ? trq[rsp_id][0].meta : 1'b0;
        for (int i = 0; i < 4; i++) begin
            int unsigned u0;
            u0  = ucnt[i];
            set = 0;
            if (rsp_valid && rsp_last && rsp_id == 2'(i)) begin
                if (trq[i].size() > 0) void'(trq[i].pop_front());
                else if (u0 > 0)       ucnt[i]--;
                else                   set = 1;
            end
            if (req_valid && req_id == 2'(i)) begin
                if (u0 == 0 && trq[i].size() < NO) begin
                    e.addr = req_addr; e.meta = req_meta[0];
                    trq[i].push_back(e);
                end else if (ucnt[i] < UMAX) ucnt[i]++;
                else set = 1;
            end
            m_desync[i] = set ? 1'b1 : (m_desync[i] & ~desync_clr[i]);
        end
        t = (thr == 0) ? 1 : int'(thr);
        for (int k = 0; k < 2; k++) begin
            esz      = eq[k].size();
            m_irq[k] = (esz >= t);
            if (err_pop && eq[k].size() > 0) void'(eq[k].pop_front());
            dropped = 0;
            if (hit) begin
                if (eq[k].size() < NS) eq[k].push_back(r);
                else begin
                    dropped = 1;
                    if (k == 1) begin void'(eq[k].pop_front()); eq[k].push_back(r); end
                end
            end
            if (drop_clr)                          m_drop[k] = dropped ? 1 : 0;
            else if (dropped && m_drop[k] < 65535) m_drop[k]++;
        end
    endtask

    task automatic check_all();
        rec_t h;
        for (int k = 0; k < 2; k++) begin
            h = (eq[k].size() > 0) ? eq[k][0] : '0;
            chk($sformatf("valid%0d", k),  o_valid[k],  eq[k].size() > 0);
            chk($sformatf("code%0d", k),   o_code[k],   h.err);
            chk($sformatf("id%0d", k),     o_id[k],     h.id);
            chk($sformatf("addr%0d", k),   o_addr[k],   h.addr);
            chk($sformatf("meta%0d", k),   o_meta[k],   h.meta);
            chk($sformatf("av%0d", k),     o_av[k],     h.av);
            chk($sformatf("drop%0d", k),   o_drop[k],   m_drop[k]);
            chk($sformatf("irq%0d", k),    o_irq[k],    m_irq[k]);
            chk($sformatf("desync%0d", k), o_desync[k], m_desync);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic req(input logic [1:0] id, input logic [47:0] a);
        idle(); req_valid = 1; req_id = id; req_addr = a; tick(); idle();
    endtask

    task automatic rsp(input logic [1:0] id, input logic last, input logic [2:0] e, input logic pop);
        idle(); rsp_valid = 1; rsp_last = last; rsp_id = id; rsp_err = e; err_pop = pop; tick(); idle();
    endtask

    task automatic pop_one();
        idle(); err_pop = 1; tick(); idle();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        err_mask = 3'b111; thr = 3'd1;
        for (int i = 0; i < 4; i++) ucnt[i] = 0;
        m_desync = '0; m_irq = '0; m_drop[0] = 0; m_drop[1] = 0;
        repeat (3) @(negedge clk);
        chk("rst_valid", o_valid, 2'b00);
        chk("rst_irq",   o_irq,   2'b00);
        chk("rst_drop",  o_drop[0], 16'd0);
        chk("rst_desync", o_desync[1], 4'd0);
        chk("rst_addr",  o_addr[0], 48'd0);
        rst_n = 1'b1;
        tick();

        // Single error with known address
        req(2'd1, 48'h1000);
        rsp(2'd1, 1'b1, 3'd2, 1'b0);
        chk("t1_valid", o_valid[0], 1'b1);
        chk("t1_code",  o_code[0], 3'd2);
        chk("t1_id",    o_id[0], 2'd1);
        chk("t1_addr",  o_addr[0], 48'h1000);
        chk("t1_av",    o_av[0], 1'b1);
        chk("t1_irq0",  o_irq[0], 1'b0);
        tick();
        chk("t1_irq1",  o_irq[0], 1'b1);
        pop_one();
        tick();
        chk("t1_irq_off", o_irq[0], 1'b0);

        // Out-of-order responses across IDs
        req(2'd0, 48'hA0);
        req(2'd1, 48'hB0);
        rsp(2'd1, 1'b1, 3'd1, 1'b0);
        rsp(2'd0, 1'b1, 3'd3, 1'b0);
        chk("t2_code_a", o_code[0], 3'd1);
        chk("t2_addr_a", o_addr[0], 48'hB0);
        pop_one();
        chk("t2_code_b", o_code[0], 3'd3);
        chk("t2_id_b",   o_id[0], 2'd0);
        chk("t2_addr_b", o_addr[0], 48'hA0);
        pop_one();

        // Tracker overflow and resynchronisation
        for (int i = 0; i < 6; i++) req(2'd2, 48'(i * 16));
        for (int i = 0; i < 6; i++) begin
            rsp(2'd2, 1'b1, 3'd1, 1'b1);
            chk("t3_av",   o_av[0], (i < 4) ? 1'b1 : 1'b0);
            chk("t3_addr", o_addr[0], (i < 4) ? 48'(i * 16) : 48'd0);
        end
        pop_one();
        req(2'd2, 48'h60);
        rsp(2'd2, 1'b1, 3'd1, 1'b0);
        chk("t3_resync_addr", o_addr[0], 48'h60);
        chk("t3_resync_av",   o_av[0], 1'b1);
        chk("t3_desync",      o_desync[0][2], 1'b0);
        pop_one();

        // Error FIFO overflow under both policies
        for (int i = 1; i <= 5; i++) rsp(2'd0, 1'b0, 3'(i), 1'b0);
        chk("t4_drop0", o_drop[0], 16'd1);
        chk("t4_drop1", o_drop[1], 16'd1);
        chk("t4_head0", o_code[0], 3'd1);
        chk("t4_head1", o_code[1], 3'd2);
        repeat (4) pop_one();
        idle(); drop_clr = 1; tick(); idle();
        chk("t4_clr", o_drop[0], 16'd0);

        // Masking and desync set/clear
        err_mask = 3'b011;
        rsp(2'd0, 1'b0, 3'd4, 1'b0);
        chk("t5_masked", o_valid[0], 1'b0);
        err_mask = 3'b111;
        rsp(2'd3, 1'b1, 3'd0, 1'b0);
        chk("t5_desync_set", o_desync[0][3], 1'b1);
        idle(); desync_clr = 4'b1000; tick(); idle();
        chk("t5_desync_clr", o_desync[0][3], 1'b0);

        // IRQ threshold
        thr = 3'd3;
        rsp(2'd0, 1'b0, 3'd1, 1'b0);
        rsp(2'd0, 1'b0, 3'd2, 1'b0);
        tick();
        chk("t6_irq_two", o_irq[0], 1'b0);
        rsp(2'd0, 1'b0, 3'd3, 1'b0);
        tick();
        chk("t6_irq_three", o_irq[0], 1'b1);
        pop_one();
        tick();
        chk("t6_irq_pop", o_irq[0], 1'b0);
        repeat (2) pop_one();
        thr = 3'd1;

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            req_valid  = ($urandom_range(0, 99) < 50);
            req_id     = 2'($urandom_range(0, 3));
            req_addr   = {16'($urandom), 32'($urandom)};
            req_meta   = 1'($urandom);
            rsp_valid  = ($urandom_range(0, 99) < 50);
            rsp_last   = ($urandom_range(0, 99) < 70);
            rsp_id     = 2'($urandom_range(0, 3));
            rsp_err    = ($urandom_range(0, 1) == 1) ? 3'($urandom) : 3'd0;
            err_pop    = ($urandom_range(0, 99) < 30);
            drop_clr   = ($urandom_range(0, 99) < 3);
            desync_clr = ($urandom_range(0, 99) < 5) ? 4'($urandom) : 4'd0;
            if ($urandom_range(0, 99) < 5) err_mask = 3'($urandom);
            if ($urandom_range(0, 99) < 5) thr = 3'($urandom_range(0, 4));
            tick();
        end
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_err_unit_id_tracked.md
Name: bus_err_unit_id_tracked

Overview:
- Bus error unit generalised to ID-tagged, out-of-order-across-IDs buses (AXI-style). Responses are in order within an ID only.
- Records the request address and metadata per ID.
- On an erroring last-beat response, pairs the response with the oldest outstanding request of that ID and pushes an error record into a bounded error FIFO.
- Adds lossless resynchronisation after tracker overflow, an error-code mask, a programmable IRQ threshold, and a saturating drop counter. Sits beside a manager port; SW-visible via a register wrapper.

Parameters:
- AddrWidth, 48, request address width.
- MetaDataWidth, 1, per-request sideband width.
- ErrBits, 3, response error code width.
- IdWidth, 2, transaction ID width; NumIds = 2**IdWidth trackers.
- NumOutstanding, 4, tracked entries per ID (power of 2, >=2).
- UntrackedCntWidth, 6, width of per-ID untracked-request counter.
- NumStoredErrors, 4, error FIFO depth (>=2).
- DropCntWidth, 16, drop counter width.
- DropOldest, 1'b0, when 1, a full error FIFO evicts its oldest entry instead of discarding the new error.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- testmode_i  in  1  passed to FIFOs
- req_valid_i  in  1  request handshake (valid&ready) occurred
- req_id_i  in  IdWidth  request ID
- req_addr_i  in  AddrWidth  request address
- req_meta_i  in  MetaDataWidth  request sideband
- rsp_valid_i  in  1  response beat handshake occurred
- rsp_last_i  in  1  last beat of burst
- rsp_id_i  in  IdWidth  response ID
- rsp_err_i  in  ErrBits  error code; 0 = OK
- err_mask_i  in  ErrBits  per-bit enable; error reported iff |(rsp_err_i & err_mask_i)
- irq_threshold_i  in  clog2(NumStoredErrors)+1  IRQ when stored count >= value; 0 is treated as 1
- err_irq_o  out  1  level interrupt
- err_valid_o  out  1  error FIFO non-empty
- err_pop_i  in  1  pop head; ignored when empty
- err_code_o  out  ErrBits  head error code
- err_id_o  out  IdWidth  head ID
- err_addr_o  out  AddrWidth  head address; 0 when addr_valid=0
- err_meta_o  out  MetaDataWidth  head meta; 0 when addr_valid=0
- err_addr_valid_o  out  1  head address known
- err_drop_cnt_o  out  DropCntWidth  saturating count of lost error records
- drop_cnt_clr_i  in  1  clear drop counter
- desync_o  out  NumIds  sticky per-ID loss flag (untracked counter saturated or spurious response)
- desync_clr_i  in  NumIds  per-ID clear of desync_o

Behaviour:
- Reset: all FIFOs empty, all counters 0, desync_o=0. Outputs err_irq_o=0, err_valid_o=0, err_drop_cnt_o=0; head outputs 0.
- Per-ID tracker state: addr FIFO (depth NumOutstanding) and untracked counter U.
- Request to ID i:
  - If U==0 and FIFO not full: push {addr, meta}.
  - Otherwise increment U. Requests never enter the FIFO while U>0, which preserves order.
  - If U is saturated, U holds and desync_o[i] is set.
- rsp_valid_i & rsp_last_i to ID i:
  - FIFO non-empty: pop FIFO; address known.
  - Else if U>0: decrement U; address unknown.
  - Else: spurious; set desync_o[i]; address unknown.
- Non-last beats do not pop, but their errors are still reported using the current head, without popping.
- Same cycle, same ID, request and last response:
  - Pop is evaluated on pre-cycle state.
  - FIFO full and U==0: pop and push both occur.
  - U>0 with FIFO empty: U is unchanged.
  - Empty FIFO and U==0: the response is spurious; the request is then tracked normally.
- Error capture:
  - Condition: rsp_valid_i & |(rsp_err_i & err_mask_i).
  - Record {rsp_err_i, rsp_id_i, addr, meta, addr_valid} is written into the error FIFO on the next clock edge.
  - err_valid_o rises 1 cycle after the error beat.
- Error FIFO full:
  - DropOldest=0: new record discarded; drop count +1.
  - DropOldest=1: head evicted, new record pushed; drop count +1.
  - A user pop in the same cycle frees space, so there is no drop.
- Drop counter:
  - Saturates at all-ones.
  - Clear and increment in the same cycle yield 1.
- err_irq_o = registered (usage >= max(irq_threshold_i, 1)); updates 1 cycle after usage changes.
- desync_o: set has priority over clear in the same cycle.
- No reset mid-operation recovery beyond async reset; reset discards all state.

Decomposition:
- Package bus_err_pkg holds:
  - parametrised helper functions for widths (clog2-based);
  - the error-record field order {err, id, addr, meta, addr_valid} as a documented constant.
- Sub-module bus_err_id_tracker, one per ID via generate. It contains the addr FIFO (fifo_v3), the U counter, the desync flag and the pop/lookup logic.
- The top level contains the ID demux, the response mux, the error FIFO (fifo_v3), the drop counter and the IRQ logic.

Test Plan:
- Single error: req id=1 addr=0x1000, rsp id=1 last err=2 mask=0b111 -> err_valid_o after 1 cycle; code=2, id=1, addr=0x1000, addr_valid=1; irq with threshold 1.
- Out-of-order IDs: reqs id0 0xA0, id1 0xB0; rsp id1 err=1 then id0 err=3 -> records (1,id1,0xB0) then (3,id0,0xA0).
- Overflow resync: 6 reqs id2 addrs 0x0..0x50 step 0x10 with NumOutstanding=4 -> U=2. 6 erroring last rsps -> 4 known addrs 0x0..0x30, then 2 addr_valid=0. Next req 0x60 + err rsp -> addr 0x60 valid; desync_o[2]=0.
- Error FIFO full, DropOldest=0: 5 errors, no pops -> 4 stored (first four), drop_cnt=1. With DropOldest=1: errors 2..5 stored, drop_cnt=1.
- Mask and clear: rsp err=4 with mask=0b011 -> nothing stored. Spurious last rsp on id3 -> desync_o[3]=1; desync_clr_i[3] -> 0 next cycle.
- Threshold: irq_threshold_i=3 with 2 stored -> irq=0; third stored -> irq=1 one cycle later; pop one -> irq=0.
